uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_sync.sv | 34 +++
 rtl/uart_rx.sv | 143 ++++++++++++++
 tb/tb_uart_rx.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default framing
// constants and bit-period helpers used by both uart_tx and uart_rx.
package uart_pkg;

  localparam int OVERSAMPLING_DEF = 8;
  localparam int DATA_BITS_DEF    = 8;

  localparam int HALF_BIT_TICKS_DEF = OVERSAMPLING_DEF / 2;
  localparam int FULL_BIT_TICKS_DEF = OVERSAMPLING_DEF;

  typedef logic [1:0] rx_state_t;

  localparam logic [1:0] RX_IDLE  = 2'b00;
  localparam logic [1:0] RX_START = 2'b01;
  localparam logic [1:0] RX_DATA  = 2'b10;
  localparam logic [1:0] RX_STOP  = 2'b11;

  function automatic int half_bit_ticks(input int oversampling);
    return oversampling / 2;
  endfunction

  function automatic int full_bit_ticks(input int oversampling);
    return oversampling;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus a tick-rate history flop,
// so a falling edge is judged between consecutive oversampling ticks.
module uart_rx_sync (
  input  logic sysclk_in,
  input  logic nrst_in,
  input  logic baud_tick_in,
  input  logic rx_serial_in,
  output logic rx_sync_o,
  output logic fall_det_o
);

  logic sync1_q;
  logic sync2_q;
  logic hist_q;

  always_ff @(posedge sysclk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
    end else begin
      sync1_q <= rx_serial_in;
      sync2_q <= sync1_q;
      // History only advances on ticks: a line that is already low never looks like a new edge
      if (baud_tick_in) begin
        hist_q <= sync2_q;
      end
    end
  end

  assign rx_sync_o  = sync2_q;
  assign fall_det_o = hist_q & ~sync2_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start detection, mid-bit sampling of LSB-first
// data and one stop bit, with one-cycle valid and framing-error strobes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLING = OVERSAMPLING_DEF,
  parameter int DATA_BITS    = DATA_BITS_DEF
) (
  input  logic                 sysclk_in,
  input  logic                 nrst_in,
  input  logic                 baud_tick_in,
  input  logic                 rx_serial_in,
  output logic [DATA_BITS-1:0] rx_data_out,
  output logic                 rx_valid_out,
  output logic                 rx_busy_out,
  output logic                 rx_frame_err_out
);

  localparam int TICK_W = $clog2(OVERSAMPLING);
  localparam int IDX_W  = $clog2(DATA_BITS) + 1;

  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(half_bit_ticks(OVERSAMPLING) - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(full_bit_ticks(OVERSAMPLING) - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DATA_BITS - 1);

  logic rx_sync;
  logic fall_det;

  uart_rx_sync u_sync (
    .sysclk_in   (sysclk_in),
    .nrst_in     (nrst_in),
    .baud_tick_in(baud_tick_in),
    .rx_serial_in(rx_serial_in),
    .rx_sync_o   (rx_sync),
    .fall_det_o  (fall_det)
  );

  rx_state_t            state_q, state_d;
  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      RX_IDLE: begin
        if (baud_tick_in && fall_det) begin
          state_d    = RX_START;
          tick_cnt_d = '0;
        end
      end

      RX_START: begin
        if (baud_tick_in) begin
          if (tick_cnt_q == HALF_LAST) begin
            // A start bit that is already high again at its centre was noise
            if (!rx_sync) begin
              state_d    = RX_DATA;
              tick_cnt_d = '0;
              bit_idx_d  = '0;
            end else begin
              state_d = RX_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
      end

      RX_DATA: begin
        if (baud_tick_in) begin
          if (tick_cnt_q == FULL_LAST) begin
            shift_d    = {rx_sync, shift_q[DATA_BITS-1:1]};
            bit_idx_d  = bit_idx_q + IDX_W'(1);
            tick_cnt_d = '0;
            if (bit_idx_q == LAST_IDX) begin
              state_d = RX_STOP;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
      end

      RX_STOP: begin
        if (baud_tick_in) begin
          if (tick_cnt_q == FULL_LAST) begin
            if (rx_sync) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            tick_cnt_d = '0;
            state_d    = RX_IDLE;
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
      end

      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge sysclk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      state_q    <= RX_IDLE;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign rx_data_out      = data_q;
  assign rx_valid_out     = valid_q;
  assign rx_frame_err_out = err_q;
  assign rx_busy_out      = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: drives whole serial frames at 32 sysclk per bit and
// compares the observed strobe stream against a frame-level expectation queue.
module tb_uart_rx;

  localparam int OS       = 8;
  localparam int DB       = 8;
  localparam int BIT_CLKS = 32;

  logic          sysclk_in = 1'b0;
  logic          nrst_in;
  logic          baud_tick_in;
  logic          rx_serial_in;
  logic [DB-1:0] rx_data_out;
  logic          rx_valid_out;
  logic          rx_busy_out;
  logic          rx_frame_err_out;

  int checks = 0;
  int passes = 0;

  typedef struct {
    bit            is_valid;
    logic [DB-1:0] data;
  } ev_t;

  ev_t ev_q[$];
  ev_t exp_q[$];

  int        width_viol = 0;
  int        both_viol  = 0;
  logic      prev_valid = 1'b0;
  logic      prev_err   = 1'b0;
  int        tick_div   = 0;
  logic [9:0] busy_trace;

  uart_rx #(.OVERSAMPLING(OS), .DATA_BITS(DB)) dut (
    .sysclk_in       (sysclk_in),
    .nrst_in         (nrst_in),
    .baud_tick_in    (baud_tick_in),
    .rx_serial_in    (rx_serial_in),
    .rx_data_out     (rx_data_out),
    .rx_valid_out    (rx_valid_out),
    .rx_busy_out     (rx_busy_out),
    .rx_frame_err_out(rx_frame_err_out)
  );

  always #5 sysclk_in = ~sysclk_in;

  // One tick every 4 sysclk, changed away from the active edge
  initial baud_tick_in = 1'b0;
  always @(negedge sysclk_in) begin
    tick_div     = (tick_div + 1) % 4;
    baud_tick_in = (tick_div == 0);
  end

  // Strobe monitor: records every pulse and flags over-long or overlapping ones
  always @(negedge sysclk_in) begin
    if (rx_valid_out === 1'b1) ev_q.push_back('{1'b1, rx_data_out});
    if (rx_frame_err_out === 1'b1) ev_q.push_back('{1'b0, '0});
    if ((prev_valid && rx_valid_out) || (prev_err && rx_frame_err_out)) width_viol++;
    if (rx_valid_out && rx_frame_err_out) both_viol++;
    prev_valid = rx_valid_out;
    prev_err   = rx_frame_err_out;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge sysclk_in);
  endtask

  // Drives one frame; samples busy late in each bit and just before the stop bit ends
  task automatic send_frame(input logic [DB-1:0] d, input logic stop);
    rx_serial_in = 1'b0;
    wait_clks(28);
    busy_trace[0] = rx_busy_out;
    wait_clks(4);
    for (int i = 0; i < DB; i++) begin
      rx_serial_in = d[i];
      wait_clks(28);
      busy_trace[i+1] = rx_busy_out;
      wait_clks(4);
    end
    rx_serial_in = stop;
    wait_clks(30);
    busy_trace[9] = rx_busy_out;
    wait_clks(2);
  endtask

  task automatic check_events(input string name);
    checks++;
    if (ev_q.size() !== exp_q.size())
      $display("FAIL %s event count: got %0d expected %0d", name, ev_q.size(), exp_q.size());
    else
      passes++;
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
      checks++;
      if (ev_q[i].is_valid !== exp_q[i].is_valid || ev_q[i].data !== exp_q[i].data)
        $display("FAIL %s event %0d: got valid=%0b data=%h expected valid=%0b data=%h",
                 name, i, ev_q[i].is_valid, ev_q[i].data, exp_q[i].is_valid, exp_q[i].data);
      else
        passes++;
    end
    $display("%s: %0d events observed, %0d expected", name, ev_q.size(), exp_q.size());
  endtask

  task automatic test_reset();
    nrst_in      = 1'b0;
    rx_serial_in = 1'b1;
    wait_clks(5);
    checks++;
    if ({rx_data_out, rx_valid_out, rx_busy_out, rx_frame_err_out} !== 11'h0)
      $display("FAIL reset_outputs: got data=%h v=%b b=%b e=%b expected all 0",
               rx_data_out, rx_valid_out, rx_busy_out, rx_frame_err_out);
    else passes++;
    nrst_in = 1'b1;
    wait_clks(40);
    checks++;
    if (rx_busy_out !== 1'b0 || ev_q.size() != 0)
      $display("FAIL idle_after_reset: got busy=%b events=%0d expected 0/0", rx_busy_out, ev_q.size());
    else passes++;
  endtask

  task automatic test_good_frame();
    ev_q.delete(); exp_q.delete();
    exp_q.push_back('{1'b1, 8'hA5});
    send_frame(8'hA5, 1'b1);
    wait_clks(16);
    check_events("good_frame");
    checks++;
    if (busy_trace !== 10'b01_1111_1111)
      $display("FAIL good_frame_busy: got trace=%b expected %b", busy_trace, 10'b01_1111_1111);
    else passes++;
    checks++;
    if (rx_data_out !== 8'hA5)
      $display("FAIL good_frame_data: got %h expected a5", rx_data_out);
    else passes++;
  endtask

  task automatic test_glitch();
    ev_q.delete(); exp_q.delete();
    rx_serial_in = 1'b0;
    wait_clks(8);
    checks++;
    if (rx_busy_out !== 1'b1)
      $display("FAIL glitch_busy_rise: got %b expected 1", rx_busy_out);
    else passes++;
    rx_serial_in = 1'b1;
    wait_clks(32);
    checks++;
    if (rx_busy_out !== 1'b0)
      $display("FAIL glitch_busy_drop: got %b expected 0", rx_busy_out);
    else passes++;
    wait_clks(64);
    check_events("glitch");
    checks++;
    if (rx_data_out !== 8'hA5)
      $display("FAIL glitch_data_held: got %h expected a5", rx_data_out);
    else passes++;
  endtask

  task automatic test_frame_err();
    ev_q.delete(); exp_q.delete();
    exp_q.push_back('{1'b0, '0});
    send_frame(8'h3C, 1'b0);
    rx_serial_in = 1'b1;
    wait_clks(64);
    check_events("frame_err");
    checks++;
    if (rx_data_out !== 8'hA5)
      $display("FAIL frame_err_data_held: got %h expected a5", rx_data_out);
    else passes++;
  endtask

  task automatic test_back_to_back();
    ev_q.delete(); exp_q.delete();
    exp_q.push_back('{1'b1, 8'h00});
    exp_q.push_back('{1'b1, 8'hFF});
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_clks(32);
    check_events("back_to_back");
  endtask

  task automatic test_break();
    ev_q.delete(); exp_q.delete();
    exp_q.push_back('{1'b0, '0});
    exp_q.push_back('{1'b1, 8'h55});
    rx_serial_in = 1'b0;
    wait_clks(30 * BIT_CLKS);
    rx_serial_in = 1'b1;
    wait_clks(2 * BIT_CLKS);
    send_frame(8'h55, 1'b1);
    wait_clks(32);
    check_events("break");
  endtask

  task automatic test_reset_mid();
    logic [DB-1:0] partial;
    ev_q.delete(); exp_q.delete();
    partial = 8'h81;
    rx_serial_in = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 3; i++) begin
      rx_serial_in = partial[i];
      wait_clks(BIT_CLKS);
    end
    checks++;
    if (rx_busy_out !== 1'b1)
      $display("FAIL reset_mid_busy_before: got %b expected 1", rx_busy_out);
    else passes++;
    nrst_in = 1'b0;
    #1;
    checks++;
    if ({rx_data_out, rx_valid_out, rx_busy_out, rx_frame_err_out} !== 11'h0)
      $display("FAIL reset_mid_outputs: got data=%h v=%b b=%b e=%b expected all 0",
               rx_data_out, rx_valid_out, rx_busy_out, rx_frame_err_out);
    else passes++;
    wait_clks(10);
    rx_serial_in = 1'b1;
    wait_clks(10);
    nrst_in = 1'b1;
    wait_clks(2 * BIT_CLKS);
    exp_q.push_back('{1'b1, 8'h42});
    send_frame(8'h42, 1'b1);
    wait_clks(32);
    check_events("reset_mid");
  endtask

  task automatic test_random();
    logic [DB-1:0] last_good;
    logic [DB-1:0] d;
    logic          stop;
    ev_q.delete(); exp_q.delete();
    last_good = rx_data_out;
    for (int n = 0; n < 16; n++) begin
      d    = DB'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      if (stop) begin
        exp_q.push_back('{1'b1, d});
        last_good = d;
      end else begin
        exp_q.push_back('{1'b0, '0});
      end
      send_frame(d, stop);
      rx_serial_in = 1'b1;
      // A low stop bit needs idle high time before the next start edge can be seen
      wait_clks(stop ? $urandom_range(0, 40) : BIT_CLKS + $urandom_range(0, 40));
    end
    wait_clks(64);
    check_events("random");
    checks++;
    if (rx_data_out !== last_good)
      $display("FAIL random_data_held: got %h expected %h", rx_data_out, last_good);
    else passes++;
    checks++;
    if (width_viol !== 0 || both_viol !== 0)
      $display("FAIL strobe_shape: got width_viol=%0d both_viol=%0d expected 0/0", width_viol, both_viol);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_break();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
